// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared register-file constants for the writeback arbiter slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; scan starts at ptr, wraps mod N.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             w_found;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin share of the register-file write port plus a RAW busy
//          scoreboard. Optional macro REGFILE_WB_BYPASS_EN adds write forwarding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = regfile_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_addr,
    input  logic [NUM_REQ*XLEN-1:0]       req_rd_data,
    input  logic                          alloc_valid,
    input  logic [REG_ADDR_W-1:0]         alloc_addr,
    input  logic [REG_ADDR_W-1:0]         rs1_addr,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                          rs1_fwd,
    output logic                          rs2_fwd,
    output logic [XLEN-1:0]               rs1_fwd_data,
    output logic [XLEN-1:0]               rs2_fwd_data,
`endif
    output logic                          rd_en,
    output logic [REG_ADDR_W-1:0]         rd_addr,
    output logic [XLEN-1:0]               rd_data
);

    import regfile_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [REG_ADDR_W-1:0] c_ZERO = REG_ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic [NUM_REQ-1:0]    w_req;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [XLEN-1:0]       w_sel_data;

    // Masking requests during reset keeps every ready low while rst is high.
    assign w_req = rst ? '0 : req_valid;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready  = w_gnt;
    assign w_xfer     = |w_gnt;
    assign w_sel_addr = req_rd_addr[int'(w_gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign w_sel_data = req_rd_data[int'(w_gnt_idx)*XLEN +: XLEN];
    assign w_ptr_nxt  = (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;

    // Clear before set so a fresh allocation survives a same-cycle writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        if (rd_en) begin
            w_busy_nxt[rd_addr] = 1'b0;
        end
        if (alloc_valid) begin
            w_busy_nxt[alloc_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_busy   <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            rd_en  <= w_xfer && (w_sel_addr != c_ZERO);
            if (w_xfer) begin
                r_rr_ptr <= w_ptr_nxt;
                rd_addr  <= w_sel_addr;
                rd_data  <= w_sel_data;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_fwd      = rd_en && (rd_addr == rs1_addr) && (rs1_addr != c_ZERO);
    assign rs2_fwd      = rd_en && (rd_addr == rs2_addr) && (rs2_addr != c_ZERO);
    assign rs1_fwd_data = rd_data;
    assign rs2_fwd_data = rd_data;
    // A matching allocation this cycle means a newer producer, so keep the stall.
    assign rs1_busy = r_busy[rs1_addr] &&
                      !(rs1_fwd && !(alloc_valid && (alloc_addr == rs1_addr)));
    assign rs2_busy = r_busy[rs2_addr] &&
                      !(rs2_fwd && !(alloc_valid && (alloc_addr == rs2_addr)));
`else
    assign rs1_busy = r_busy[rs1_addr];
    assign rs2_busy = r_busy[rs2_addr];
`endif

endmodule

`default_nettype wire
